// File: rtl/aes_round_seq.sv
// aes_round_seq: iterative AES-128 encryption sequencer driving an external round datapath
//   key_valid/w          : expanded key (round key r = w[128*r+127 -: 128]) and its qualifier
//   in_valid/in_ready    : plaintext handshake, in_data is the plaintext block
//   abort                : synchronous cancel of the block in flight
//   rd_state/rd_key/rd_last -> rd_result : one AES round per cycle in the external unit
//   out_valid/out_ready  : ciphertext handshake, out_data is held until accepted
//   busy/round/err       : status; err pulses when key_valid is lost mid-encryption
module aes_round_seq (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [1407:0] w,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic          abort,
    output logic [127:0]  rd_state,
    output logic [127:0]  rd_key,
    output logic          rd_last,
    input  logic [127:0]  rd_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy,
    output logic [3:0]    round,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t        state_q;
    logic [127:0]  st_q;
    logic [127:0]  out_data_q;
    logic [3:0]    round_q;
    logic          err_q;
    logic          in_round;
    logic          accept;
    assign in_round  = state_q == ROUND;
    // a DONE block that is being drained can hand its slot straight to the next plaintext
    assign in_ready  = key_valid && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign rd_state  = in_round ? st_q : '0;
    assign rd_key    = in_round ? w[{round_q, 7'd0} +: 128] : '0;
    assign rd_last   = in_round && round_q == 4'd10;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_data  = out_data_q;
    assign round     = round_q;
    assign err       = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            st_q       <= '0;
            round_q    <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                round_q <= '0;
            end else if (in_round && !key_valid) begin
                state_q <= IDLE;
                round_q <= '0;
                err_q   <= 1'b1;
            end else if (accept) begin
                st_q    <= in_data ^ w[127:0];
                round_q <= 4'd1;
                state_q <= ROUND;
            end else if (in_round) begin
                st_q <= rd_result;
                if (round_q == 4'd10) begin
                    out_data_q <= rd_result;
                    round_q    <= '0;
                    state_q    <= DONE;
                end else begin
                    round_q <= round_q + 4'd1;
                end
            end else if (state_q == DONE && out_ready) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: directed bench for aes_round_seq with an attached behavioural AES round unit
module tb_aes_round_seq;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_valid;
    logic [1407:0] w;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          abort;
    logic [127:0]  rd_state;
    logic [127:0]  rd_key;
    logic          rd_last;
    logic [127:0]  rd_result;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          busy;
    logic [3:0]    round;
    logic          err;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    logic [7:0]   sbox [256];
    logic [127:0] cur_key;
    logic [127:0] bb [3];

    aes_round_seq dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .w(w),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .abort(abort),
        .rd_state(rd_state), .rd_key(rd_key), .rd_last(rd_last), .rd_result(rd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round(round), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic init_sbox;
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // state byte i is bits [127-8i -: 8]; column c holds bytes 4c..4c+3
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
            else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o ^ k;
    endfunction

    function automatic logic [1407:0] kexp(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] v;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) v[128*(i/4)+127-32*(i%4) -: 32] = wd[i];
        return v;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [1407:0] v;
        logic [127:0]  s;
        v = kexp(key);
        s = pt ^ v[127:0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, v[128*r +: 128], r == 10);
        return s;
    endfunction

    always_comb rd_result = aes_round(rd_state, rd_key, rd_last);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc_n);
    endtask

    task automatic set_key(input logic [127:0] k);
        cur_key = k;
        w = kexp(k);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // transaction-level model: age counts cycles since the block was accepted
    logic        m_act, m_err, e_done, e_in_ready, e_acc;
    int          m_age;
    logic [3:0]  e_round;
    logic [127:0] m_ct;
    int          acc_t [$];
    logic [127:0] out_q [$];

    always_comb begin
        e_done     = m_act && m_age > 10;
        e_in_ready = key_valid && (!m_act || (e_done && out_ready));
        e_acc      = in_valid && e_in_ready;
        e_round    = (m_act && m_age <= 10) ? 4'(m_age) : 4'd0;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_age <= 0;
            m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (e_done && out_ready && !abort) out_q.push_back(out_data);
            if (abort) begin
                m_act <= 1'b0;
            end else if (m_act && !e_done && !key_valid) begin
                m_act <= 1'b0;
                m_err <= 1'b1;
            end else if (e_acc) begin
                m_act <= 1'b1;
                m_age <= 1;
                m_ct  <= aes_enc(in_data, cur_key);
                acc_t.push_back(cyc_n);
            end else if (e_done && out_ready) begin
                m_act <= 1'b0;
            end else if (m_act) begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 128'(in_ready), 128'(e_in_ready));
            chk("busy", 128'(busy), 128'(m_act));
            chk("round", 128'(round), 128'(e_round));
            chk("out_valid", 128'(out_valid), 128'(e_done));
            chk("rd_last", 128'(rd_last), 128'(e_round == 4'd10));
            chk("err", 128'(err), 128'(m_err));
            chk("rd_key", rd_key, e_round != 4'd0 ? w[128*e_round +: 128] : 128'h0);
            if (e_done) chk("out_data", out_data, m_ct);
            if (e_round == 4'd0) chk("rd_state_idle", rd_state, 128'h0);
        end
    end

    task automatic rst_check(input string nm);
        chk({nm, "_out_data"}, out_data, 128'h0);
        chk({nm, "_out_valid"}, 128'(out_valid), 128'h0);
        chk({nm, "_busy"}, 128'(busy), 128'h0);
        chk({nm, "_round"}, 128'(round), 128'h0);
        chk({nm, "_err"}, 128'(err), 128'h0);
        chk({nm, "_rd_state"}, rd_state, 128'h0);
        chk({nm, "_rd_key"}, rd_key, 128'h0);
        chk({nm, "_rd_last"}, 128'(rd_last), 128'h0);
        chk({nm, "_in_ready"}, 128'(in_ready), 128'(key_valid));
    endtask

    task automatic accept_one(input logic [127:0] pt);
        in_data = pt;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int c;
        c = 0;
        while (!out_valid && c < 20) begin
            tick;
            c++;
        end
        chk(nm, 128'(out_valid), 128'h1);
    endtask

    task automatic wait_round(input string nm, input logic [3:0] r);
        for (int i = 0; i < 20 && round != r; i++) tick;
        chk(nm, 128'(round), 128'(r));
    endtask

    task automatic enc(input logic [127:0] pt, input logic [127:0] exp, input string nm);
        int c;
        accept_one(pt);
        c = 0;
        while (!out_valid && c < 20) begin
            chk({nm, "_round_step"}, 128'(round), 128'(c + 1));
            chk({nm, "_rd_last_step"}, 128'(rd_last), 128'(c == 9));
            tick;
            c++;
        end
        chk({nm, "_latency"}, 128'(c), 128'd10);
        chk({nm, "_round_done"}, 128'(round), 128'h0);
        chk({nm, "_ct"}, out_data, exp);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({nm, "_idle"}, 128'(busy), 128'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int k, n, c;
        logic [127:0] d;
        rst_n = 1'b1;
        key_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        abort = 1'b0;
        in_data = '0;
        init_sbox();
        set_key(K1);
        #1 rst_n = 1'b0;
        #2 rst_check("reset");
        key_valid = 1'b1;
        #1 chk("reset_in_ready_follows_key", 128'(in_ready), 128'h1);
        chk("model_fips_c1", aes_enc(P1, K1), C1);
        chk("model_fips_b", aes_enc(P2, K2), C2);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        enc(P1, C1, "c1");
        set_key(K2);
        enc(P2, C2, "fipsb");
        set_key(K1);
        // back-to-back: in_valid and out_ready held high, data advanced after each accept
        bb[0] = P1;
        bb[1] = 128'h0;
        bb[2] = ~P1;
        acc_t.delete();
        out_q.delete();
        k = 0;
        in_data = bb[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && out_q.size() < 3; i++) begin
            tick;
            if (acc_t.size() > k) begin
                k = acc_t.size();
                if (k < 3) in_data = bb[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 128'(acc_t.size()), 128'd3);
        chk("b2b_outputs", 128'(out_q.size()), 128'd3);
        if (acc_t.size() == 3) begin
            chk("b2b_gap1", 128'(acc_t[1] - acc_t[0]), 128'd11);
            chk("b2b_gap2", 128'(acc_t[2] - acc_t[1]), 128'd11);
        end
        if (out_q.size() == 3) begin
            chk("b2b_ct0", out_q[0], C1);
            chk("b2b_ct1", out_q[1], aes_enc(bb[1], K1));
            chk("b2b_ct2", out_q[2], aes_enc(bb[2], K1));
        end
        tick;
        // backpressure
        accept_one(P2);
        wait_valid("bp_valid_rise");
        d = out_data;
        n = out_q.size();
        repeat (20) tick;
        chk("bp_data_stable", out_data, d);
        chk("bp_in_ready", 128'(in_ready), 128'h0);
        chk("bp_busy", 128'(busy), 128'h1);
        chk("bp_valid_held", 128'(out_valid), 128'h1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp_one_handshake", 128'(out_q.size()), 128'(n + 1));
        chk("bp_idle", 128'(busy), 128'h0);
        chk("bp_valid_drop", 128'(out_valid), 128'h0);
        // abort at round 5
        accept_one(P1);
        wait_round("ab_reach", 4'd5);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("ab_busy", 128'(busy), 128'h0);
        chk("ab_round", 128'(round), 128'h0);
        chk("ab_err", 128'(err), 128'h0);
        c = 0;
        repeat (12) begin
            tick;
            if (out_valid || err) c++;
        end
        chk("ab_quiet", 128'(c), 128'h0);
        // key_valid lost at round 7
        accept_one(P2);
        wait_round("kv_reach", 4'd7);
        key_valid = 1'b0;
        tick;
        chk("kv_busy", 128'(busy), 128'h0);
        chk("kv_err", 128'(err), 128'h1);
        key_valid = 1'b1;
        tick;
        chk("kv_err_pulse", 128'(err), 128'h0);
        enc(P1, C1, "post_kill");
        // asynchronous reset mid-ROUND and in DONE
        accept_one(P2);
        wait_round("rr_reach", 4'd3);
        #1 rst_n = 1'b0;
        #1 rst_check("rst_round");
        tick;
        rst_n = 1'b1;
        tick;
        accept_one(P2);
        wait_valid("rd_reach");
        #1 rst_n = 1'b0;
        #1 rst_check("rst_done");
        tick;
        rst_n = 1'b1;
        tick;
        enc(P1, C1, "post_rst");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
